// File: rtl/onchip_writer_pkg.sv
// Shared types and defaults for the on-chip stream writer.
// Optional feature: ONCHIP_STREAM_WRITER_WRAP_EN (pointer wraps instead of stopping at the end of memory).
package onchip_writer_pkg;

  localparam int DEF_DEPTH      = 5000;
  localparam int DEF_ADDR_W     = 13;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/onchip_stream_writer_byte_packer.sv
// Byte packer: collects stream bytes little-endian into one memory word and
// tracks which lanes hold data so the write can carry a matching byteenable.
module byte_packer #(
  parameter int NUM_LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear_i,
  input  logic                   accept_i,
  input  logic [7:0]             data_i,
  output logic [NUM_LANES*8-1:0] word_o,
  output logic [NUM_LANES-1:0]   be_o,
  output logic                   lane_last_o
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [LW-1:0]                lane_q;
  logic [NUM_LANES-1:0][7:0]    lane_data_q;
  logic [NUM_LANES-1:0]         be_q;

  assign lane_last_o = (lane_q == LW'(NUM_LANES - 1));
  assign word_o      = lane_data_q;
  assign be_o        = be_q;

  // Lane pointer: advances per accepted byte, restarts at lane 0 on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         lane_q <= '0;
    else if (clear_i)     lane_q <= '0;
    else if (accept_i)    lane_q <= lane_last_o ? '0 : lane_q + 1'b1;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    // Per-lane byte and valid flag; clear zeroes unfilled lanes of a partial word.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lane_data_q[l] <= '0;
        be_q[l]        <= 1'b0;
      end else if (clear_i) begin
        lane_data_q[l] <= '0;
        be_q[l]        <= 1'b0;
      end else if (accept_i && lane_q == LW'(l)) begin
        lane_data_q[l] <= data_i;
        be_q[l]        <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/onchip_stream_writer.sv
// Stream-to-on-chip-RAM writer: packs an 8-bit stream into 32-bit words and
// writes them through an Avalon-MM master, one word per WRITE cycle.
// Optional feature: ONCHIP_STREAM_WRITER_WRAP_EN -- when defined the write
// pointer wraps from DEPTH-1 to 0 and capture continues; otherwise capture
// stops after the last memory word. Overflow is flagged in both cases.
module onchip_stream_writer
  import onchip_writer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              last_q, last_d;

  logic              pk_clear, pk_accept, pk_lane_last;
  logic [31:0]       pk_word;
  logic [3:0]        pk_be;

  byte_packer #(.NUM_LANES(BYTES_PER_WORD)) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (pk_clear),
    .accept_i    (pk_accept),
    .data_i      (in_data),
    .word_o      (pk_word),
    .be_o        (pk_be),
    .lane_last_o (pk_lane_last)
  );

  assign mem_clken  = 1'b1;
  assign busy       = (state_q == S_FILL) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign word_count = cnt_q;

  // State, pointer and status registers; reset returns to IDLE at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  // Next-state and output decode; memory bus is driven only in WRITE.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    last_d         = last_q;
    pk_clear       = 1'b0;
    pk_accept      = 1'b0;
    in_ready       = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_FILL;
          ptr_d    = base_addr;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          last_d   = 1'b0;
          pk_clear = 1'b1;
        end
      end
      S_FILL: begin
        in_ready  = 1'b1;
        pk_accept = in_valid;
        if (in_valid) begin
          last_d = in_last;
          if (pk_lane_last || in_last) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = ptr_q;
        mem_writedata  = pk_word;
        mem_byteenable = pk_be;
        pk_clear       = 1'b1;
        cnt_d          = cnt_q + 1'b1;
        state_d        = last_q ? S_DONE : S_FILL;
        if (ptr_q == LAST_ADDR) begin
          ovf_d = 1'b1;
`ifdef ONCHIP_STREAM_WRITER_WRAP_EN
          ptr_d = '0;
`else
          // End of memory: stop here, pointer is left on the last word.
          state_d = S_DONE;
`endif
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_onchip_stream_writer.sv
// Directed bench for onchip_stream_writer; expected values are hand-computed.
module tb_onchip_stream_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [12:0] base_addr;
  logic [7:0]  in_data;
  logic        in_valid, in_last;
  logic        in_ready;
  logic [12:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic        busy, done, overflow;
  logic [13:0] word_count;

  int errors = 0;
  int checks = 0;
  int bad_rdy = 0;
  bit chk_rdy = 0;

  logic [12:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  wb_q[$];

  onchip_stream_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .busy(busy), .done(done),
    .overflow(overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Record every write seen on the bus, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      wa_q.push_back(mem_address);
      wd_q.push_back(mem_writedata);
      wb_q.push_back(mem_byteenable);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (chk_rdy && busy === 1'b1 && in_ready !== ~mem_write) bad_rdy++;
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wb_q.delete();
  endtask

  task automatic do_start(input logic [12:0] a);
    start = 1'b1; base_addr = a;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bit got = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int i = 0; i < 20 && !got; i++) begin
      if (in_ready === 1'b1) got = 1;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("accept", 64'(got), 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    check("done", 64'(done), 64'd1);
  endtask

  task automatic check_wr(input int idx, input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    check($sformatf("wr%0d_addr", idx), 64'(wa_q[idx]), 64'(a));
    check($sformatf("wr%0d_data", idx), 64'(wd_q[idx]), 64'(d));
    check($sformatf("wr%0d_be", idx),   64'(wb_q[idx]), 64'(be));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    step(); step();
    // Reset state
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_mem_write", 64'(mem_write), 0);
    check("rst_chipselect", 64'(mem_chipselect), 0);
    check("rst_clken", 64'(mem_clken), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_word_count", 64'(word_count), 0);
    reset_n = 1'b1;
    step();

    // One full word, last on byte 4; write follows the last byte by one cycle
    clear_log();
    do_start(13'd0);
    check("t1_busy", 64'(busy), 1);
    check("t1_in_ready", 64'(in_ready), 1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
    check("t1_write_latency", 64'(mem_write), 1);
    check("t1_in_ready_write", 64'(in_ready), 0);
    wait_done();
    check("t1_nwr", 64'(wa_q.size()), 1);
    check_wr(0, 13'd0, 32'h04030201, 4'b1111);
    check("t1_word_count", 64'(word_count), 1);
    check("t1_busy_done", 64'(busy), 0);

    // Full word then partial word, started from DONE
    clear_log();
    do_start(13'd10);
    check("t2_done_cleared", 64'(done), 0);
    send_byte(8'hAA, 0); send_byte(8'hAB, 0); send_byte(8'hAC, 0);
    send_byte(8'hAD, 0); send_byte(8'hAE, 0); send_byte(8'hAF, 1);
    wait_done();
    check("t2_nwr", 64'(wa_q.size()), 2);
    check_wr(0, 13'd10, 32'hADACABAA, 4'b1111);
    check_wr(1, 13'd11, 32'h0000AFAE, 4'b0011);
    check("t2_word_count", 64'(word_count), 2);

    // in_valid every other cycle; in_ready low only during WRITE
    clear_log();
    do_start(13'd20);
    chk_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      send_byte(8'h11 + 8'(i), i == 7);
    end
    wait_done();
    chk_rdy = 0;
    check("t3_ready_only_low_in_write", 64'(bad_rdy), 0);
    check("t3_nwr", 64'(wa_q.size()), 2);
    check_wr(0, 13'd20, 32'h14131211, 4'b1111);
    check_wr(1, 13'd21, 32'h18171615, 4'b1111);

    // End-of-memory boundary
    clear_log();
    do_start(13'd4999);
    send_byte(8'h21, 0); send_byte(8'h22, 0); send_byte(8'h23, 0); send_byte(8'h24, 0);
    check("t4_write_at_end", 64'(mem_address), 64'd4999);
`ifdef ONCHIP_STREAM_WRITER_WRAP_EN
    send_byte(8'h25, 0); send_byte(8'h26, 0); send_byte(8'h27, 0); send_byte(8'h28, 1);
    wait_done();
    check("t4_nwr", 64'(wa_q.size()), 2);
    check_wr(0, 13'd4999, 32'h24232221, 4'b1111);
    check_wr(1, 13'd0, 32'h28272625, 4'b1111);
    check("t4_overflow", 64'(overflow), 1);
    check("t4_word_count", 64'(word_count), 2);
`else
    step();
    check("t4_done", 64'(done), 1);
    check("t4_overflow", 64'(overflow), 1);
    check("t4_in_ready", 64'(in_ready), 0);
    in_valid = 1'b1; in_data = 8'h25;
    step(); step(); step();
    in_valid = 1'b0;
    check("t4_in_ready_after", 64'(in_ready), 0);
    check("t4_nwr", 64'(wa_q.size()), 1);
    check_wr(0, 13'd4999, 32'h24232221, 4'b1111);
    check("t4_word_count", 64'(word_count), 1);
`endif

    // Reset asserted during the second word's WRITE
    clear_log();
    do_start(13'd30);
    send_byte(8'h31, 0); send_byte(8'h32, 0); send_byte(8'h33, 0); send_byte(8'h34, 0);
    send_byte(8'h35, 0); send_byte(8'h36, 0); send_byte(8'h37, 0); send_byte(8'h38, 0);
    check("t5_in_write", 64'(mem_write), 1);
    reset_n = 1'b0;
    #1;
    check("t5_mem_write_drop", 64'(mem_write), 0);
    check("t5_chipselect_drop", 64'(mem_chipselect), 0);
    check("t5_busy", 64'(busy), 0);
    check("t5_word_count", 64'(word_count), 0);
    check("t5_in_ready", 64'(in_ready), 0);
    check("t5_clken", 64'(mem_clken), 1);
    step();
    check("t5_nwr", 64'(wa_q.size()), 1);
    reset_n = 1'b1;
    step();
    clear_log();
    do_start(13'd40);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
    wait_done();
    check("t5_restart_nwr", 64'(wa_q.size()), 1);
    check_wr(0, 13'd40, 32'h04030201, 4'b1111);
    check("t5_restart_count", 64'(word_count), 1);
    check("t5_restart_ovf", 64'(overflow), 0);

    // start pulsed mid-FILL is ignored
    clear_log();
    do_start(13'd50);
    send_byte(8'h51, 0); send_byte(8'h52, 0);
    do_start(13'd60);
    check("t6_still_busy", 64'(busy), 1);
    send_byte(8'h53, 0); send_byte(8'h54, 1);
    wait_done();
    check("t6_nwr", 64'(wa_q.size()), 1);
    check_wr(0, 13'd50, 32'h54535251, 4'b1111);
    check("t6_word_count", 64'(word_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onchip_stream_writer.md
ONCHIP_STREAM_WRITER -- requirements
Module: onchip_stream_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 5000, memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 13, memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a capture.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, sampled on start.
REQ-007 SHALL have port in_data  input  8  stream byte.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_last  input  1  final byte of capture, qualified by in_valid.
REQ-010 SHALL have port in_ready  output  1  byte accepted when in_valid & in_ready.
REQ-011 SHALL have ports mem_address (ADDR_W), mem_writedata (32), mem_byteenable (4), mem_chipselect (1), mem_write (1), mem_clken (1)  output  Avalon-MM write master to the 32-bit on-chip RAM slave.
REQ-012 SHALL have ports busy (1), done (1), overflow (1), word_count (ADDR_W+1)  output  status.

Function
REQ-013 SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-014 IDLE: in_ready=0; start -> FILL, latch base_addr into write pointer, clear word_count, done, overflow, byte lane.
REQ-015 FILL: in_ready=1; each accepted byte goes to lane 0..3 little-endian (first byte -> bits 7:0).
REQ-016 FILL -> WRITE on acceptance of lane-3 byte or any byte with in_last=1.
REQ-017 WRITE: exactly one cycle, mem_chipselect=mem_write=1, mem_address=pointer, byteenable has one bit per filled lane (full word 4'b1111, last partial e.g. 2 bytes 4'b0011); in_ready=0.
REQ-018 After WRITE: pointer+1, word_count+1, lane cleared; -> DONE if word was in_last, else -> FILL.
REQ-019 DONE: done=1 held until next start; start in DONE behaves as in IDLE.
REQ-020 start while in FILL or WRITE SHALL be ignored.
REQ-021 mem_clken SHALL be constant 1; mem_chipselect and mem_write SHALL be 0 outside WRITE.
REQ-022 busy=1 in FILL and WRITE, else 0.
REQ-023 Throughput: 4 bytes per 5 cycles sustained; write latency 1 cycle after last byte of word.
REQ-024 Pointer at DEPTH-1 incrementing SHALL be the wrap boundary (see REQ-028).

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE; all outputs 0 (in_ready, mem_*, busy, done, overflow, word_count, mem_clken=1 excepted—mem_clken stays 1).
REQ-026 Reset during WRITE SHALL deassert mem_write immediately; a partially filled word is discarded.

Configuration
REQ-027 Macro ONCHIP_STREAM_WRITER_WRAP_EN selects overflow policy.
REQ-028 With it defined: pointer wraps DEPTH-1 -> 0, overflow set sticky, capture continues. Without it: after writing DEPTH-1, overflow=1, state -> DONE, remaining bytes not accepted.

Structure
REQ-029 Shared package onchip_writer_pkg SHALL hold the state enum and default DEPTH/ADDR_W constants.
REQ-030 One sub-module, byte_packer (lane counter, data shift, byteenable generation), SHALL be instantiated; FSM and pointer stay in the top.

Verification
REQ-031 start, base_addr=0, bytes 01,02,03,04 with in_last on 04 -> one write addr 0, data 0x04030201, be 4'b1111, done=1, word_count=1.
REQ-032 base_addr=10, 6 bytes AA..AF, in_last on AF -> writes addr 10 data 0xADACABAA be F, addr 11 data 0x0000AFAE be 4'b0011, word_count=2.
REQ-033 in_valid toggled every other cycle, 8 bytes -> two correct writes, in_ready=0 only in WRITE cycles.
REQ-034 base_addr=4999, 8 bytes: WRAP_EN defined -> writes 4999 then 0, overflow=1; undefined -> one write at 4999, overflow=1, done=1, in_ready=0 after.
REQ-035 reset_n low during WRITE cycle of second word -> mem_write drops same cycle, all status 0, next start begins cleanly.
REQ-036 start pulsed mid-FILL -> ignored, pointer and word_count unchanged.
